// File: rtl/bsg_vanilla_idiv_seq.sv
// Sequential integer divider: one restoring-division quotient bit per cycle,
// with single-cycle paths for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | ready_o=1, waiting for v_i
// CALC  | iterating, one quotient bit per cycle, MSB first
// DONE  | v_o=1, result_o/rd_o held until yumi_i
module bsg_vanilla_idiv_seq #(
  parameter int width_p          = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [1:0]                  op_i,
  input  logic [width_p-1:0]          dividend_i,
  input  logic [width_p-1:0]          divisor_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  output logic                        v_o,
  output logic [width_p-1:0]          result_o,
  output logic [reg_addr_width_p-1:0] rd_o,
  input  logic                        yumi_i
);

  typedef enum logic [1:0] {eDIV = 2'd0, eDIVU = 2'd1, eREM = 2'd2, eREMU = 2'd3} idiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int cnt_w = $clog2(width_p);
  localparam logic [cnt_w-1:0]   cnt_last = cnt_w'(width_p - 1);
  localparam logic [width_p-1:0] int_min  = {1'b1, {(width_p-1){1'b0}}};

  state_e state_r, state_n;

  logic [cnt_w-1:0]            cnt_r;
  logic [width_p-1:0]          quot_r, rem_r, dvsr_r, result_r;
  logic [reg_addr_width_p-1:0] rd_r;
  logic                        neg_q_r, neg_r_r, sel_rem_r;

  idiv_op_e           op;
  logic               accept, is_signed, div_zero, ovf, special;
  logic [width_p-1:0] mag_a, mag_b;

  assign op        = idiv_op_e'(op_i);
  assign ready_o   = (state_r == IDLE) & ~reset_i;
  assign v_o       = (state_r == DONE);
  assign accept    = v_i & ready_o;
  assign is_signed = (op == eDIV) | (op == eREM);
  assign div_zero  = (divisor_i == '0);
  assign ovf       = is_signed & (dividend_i == int_min) & (divisor_i == '1);
  assign special   = div_zero | ovf;
  assign mag_a     = (is_signed & dividend_i[width_p-1]) ? -dividend_i : dividend_i;
  assign mag_b     = (is_signed & divisor_i[width_p-1])  ? -divisor_i  : divisor_i;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in width_p+1 bits and the top bit of the difference is the borrow.
  logic [width_p:0]   rem_shift, diff;
  logic               q_bit;
  logic [width_p-1:0] rem_nxt, quot_nxt, q_fix, r_fix;

  assign rem_shift = {rem_r, quot_r[width_p-1]};
  assign diff      = rem_shift - {1'b0, dvsr_r};
  assign q_bit     = ~diff[width_p];
  assign rem_nxt   = q_bit ? diff[width_p-1:0] : rem_shift[width_p-1:0];
  assign quot_nxt  = {quot_r[width_p-2:0], q_bit};
  assign q_fix     = neg_q_r ? -quot_nxt : quot_nxt;
  assign r_fix     = neg_r_r ? -rem_nxt  : rem_nxt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (accept) state_n = special ? DONE : CALC;
      CALC:    if (cnt_r == cnt_last) state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r     <= '0;
      quot_r    <= '0;
      rem_r     <= '0;
      dvsr_r    <= '0;
      result_r  <= '0;
      rd_r      <= '0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (accept) begin
          cnt_r     <= '0;
          quot_r    <= mag_a;
          rem_r     <= '0;
          dvsr_r    <= mag_b;
          rd_r      <= rd_i;
          sel_rem_r <= op_i[1];
          neg_q_r   <= is_signed & (dividend_i[width_p-1] ^ divisor_i[width_p-1]);
          neg_r_r   <= is_signed & dividend_i[width_p-1];
          if (div_zero)  result_r <= op_i[1] ? dividend_i : '1;
          else if (ovf)  result_r <= op_i[1] ? '0 : int_min;
        end
        CALC: begin
          cnt_r  <= (cnt_r == cnt_last) ? '0 : cnt_r + 1'b1;
          quot_r <= quot_nxt;
          rem_r  <= rem_nxt;
          if (cnt_r == cnt_last) result_r <= sel_rem_r ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_r;
  assign rd_o     = rd_r;

  // A consumer may only take a result that is actually being offered.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: doc/bsg_vanilla_idiv_seq.md
BSG_VANILLA_IDIV_SEQ -- requirements
Module: bsg_vanilla_idiv_seq

Interface
REQ-001 SHALL have parameter width_p, default 32: operand and result width.
REQ-002 SHALL have parameter reg_addr_width_p, default 5: destination register tag width.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port v_i, input, 1: request valid.
REQ-006 SHALL have port ready_o, output, 1: the block can accept a request this cycle.
REQ-007 SHALL have port op_i, input, 2: operation, type idiv_op_e, encoded eDIV=0, eDIVU=1, eREM=2, eREMU=3.
REQ-008 SHALL have port dividend_i, input, width_p: rs1 value.
REQ-009 SHALL have port divisor_i, input, width_p: rs2 value.
REQ-010 SHALL have port rd_i, input, reg_addr_width_p: destination register tag.
REQ-011 SHALL have port v_o, output, 1: result valid.
REQ-012 SHALL have port result_o, output, width_p: quotient or remainder.
REQ-013 SHALL have port rd_o, output, reg_addr_width_p: tag captured with the request.
REQ-014 SHALL have port yumi_i, input, 1: consumer takes the result; asserted only while v_o=1.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, CALC and DONE; ready_o=1 only in IDLE; v_o=1 only in DONE.
REQ-016 SHALL accept a request on the cycle v_i&ready_o is 1, capturing op_i, rd_i and both operands.
REQ-017 SHALL, for eDIV/eREM, convert operands to magnitudes before iterating; eDIVU/eREMU use the raw operand bits.
REQ-018 SHALL take a special path when divisor_i==0: IDLE->DONE on the next edge, with no CALC cycles.
REQ-019 SHALL return width_p'(all ones) as the divide-by-zero result for eDIV/eDIVU.
REQ-020 SHALL return dividend_i as the divide-by-zero result for eREM/eREMU.
REQ-021 SHALL take a special path for eDIV/eREM with dividend=0x80000000 and divisor=0xFFFFFFFF: IDLE->DONE on the next edge.
REQ-022 SHALL return 0x80000000 for the REQ-021 case under eDIV, and 0 under eREM.
REQ-023 SHALL otherwise enter CALC and run restoring division, one quotient bit per cycle, MSB first, for exactly width_p cycles.
REQ-024 SHALL count CALC iterations with a $clog2(width_p)-bit counter from 0 to width_p-1, then transition CALC->DONE.
REQ-025 SHALL produce v_o=1 exactly width_p+1 cycles after the accept edge on the normal path, and 1 cycle after it on special paths.
REQ-026 SHALL apply sign fixup for eDIV: quotient negated iff the operand signs differ.
REQ-027 SHALL apply sign fixup for eREM: the remainder takes the sign of the dividend; a zero remainder stays 0.
REQ-028 SHALL select the quotient for eDIV/eDIVU and the remainder for eREM/eREMU.
REQ-029 SHALL hold result_o and rd_o stable while in DONE, for any number of cycles until yumi_i.
REQ-030 SHALL transition DONE->IDLE on yumi_i; ready_o rises the cycle after yumi_i, so no same-cycle re-accept.
REQ-031 SHALL ignore v_i in CALC and DONE; a request not accepted leaves no state.
REQ-032 SHALL treat yumi_i while v_o=0 as illegal (an assertion fires in simulation) and SHALL ignore it in logic.

Reset
REQ-033 SHALL, whenever reset_i=1 and regardless of the clock, force state=IDLE, counter=0, v_o=0, ready_o=1 (while not in reset), result_o=0 and rd_o=0.
REQ-034 SHALL discard any in-flight CALC or DONE operation when reset_i is asserted, without a result being produced after reset release.
REQ-035 SHALL accept a request on the first clock edge after reset_i deasserts.

Verification
REQ-036 SHALL pass this scenario: eDIVU 100/7, rd=5 -> v_o=1 after 33 cycles, result_o=14, rd_o=5; eREMU with the same operands -> 2.
REQ-037 SHALL pass this scenario: eDIV -7/2 -> 0xFFFFFFFD (-3); eREM -7/2 -> 0xFFFFFFFF (-1); eREM 7/-2 -> 1.
REQ-038 SHALL pass this scenario: eDIV 123/0 -> 0xFFFFFFFF one cycle after accept; eREMU 123/0 -> 123.
REQ-039 SHALL pass this scenario: eDIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle; eREM with the same operands -> 0.
REQ-040 SHALL pass this scenario: yumi_i held low 10 cycles after v_o rises -> v_o, result_o and rd_o unchanged throughout; v_i pulses in that window are ignored.
REQ-041 SHALL pass this scenario: reset_i pulsed at CALC iteration 15 -> v_o=0 and ready_o=1 immediately after release; a fresh eDIVU 9/3 -> 3.
